multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Control unit of the multicycle CPU. Decodes the 6-bit opcode held in IR and
//  sequences the shared datapath (PC, IR, register file, ALU, ALUOut, data
//  memory) through IF/ID/EXE/MEM/WB states. It drives every write enable and
//  mux select.
//  ALUOut and the ID-stage A/B/DR latches have no enable; they capture on every
//  CLK edge, so this unit only times when their contents are consumed.
// PARAMETERS
//  OPW   6  opcode width
//  STW   4  state register width
// PORTS
//  CLK        in   1  system clock; all state updates on posedge
//  RST        in   1  synchronous, active-high reset
//  opcode     in   6  IR[31:26]
//  zero       in   1  ALU zero flag, sampled in EXE_BR
//  mem_ready  in   1  data/instr memory ready (only with MEM_WAIT_EN)
//  PCWre      out  1  PC write enable
//  IRWre      out  1  IR write enable
//  RegWre     out  1  register file write enable
//  mRD,mWR    out  1  data memory read / write strobe
//  ALUSrcA    out  1  0=rs, 1=sa (sll)
//  ALUSrcB    out  1  0=rt, 1=ext(imm)
//  ExtSel     out  1  0=zero-extend (ori), 1=sign-extend
//  ALUOp      out  3  000 add,001 sub,010 sll,011 or,100 and,101 slt
//  RegDst     out  2  00=$31, 01=rt, 10=rd
//  WrRegDSrc  out  1  0=PC+4 (jal), 1=DB data
//  DBDataSrc  out  1  0=ALUOut, 1=mem DR
//  PCSrc      out  2  00=PC+4, 01=branch target, 10=rs (jr), 11=jump addr
//  state_out  out  4  current state, for debug/display
// BEHAVIOUR
//  Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001,
//   ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100,
//   j 111000, jr 111001, jal 111010, halt 111111.
//  States: IF 0000, ID 0001, EXE_AL 0110, WB_AL 0111, EXE_BR 0101,
//   EXE_LS 0010, MEM 0011, WB_LD 0100, HALT 1000.
//  Transitions:
//   IF->ID.
//   ID: j/jr/jal->IF; beq->EXE_BR; sw/lw->EXE_LS; halt->HALT;
//       R/I ALU->EXE_AL; unknown opcode->IF (treated as nop).
//   EXE_AL->WB_AL->IF. EXE_BR->IF. EXE_LS->MEM. MEM: lw->WB_LD, sw->IF.
//   WB_LD->IF. HALT->HALT until RST.
//  Outputs are combinational from state+opcode. Strobes not listed are 0.
//   IF: IRWre=1.
//   ID: j/jr/unknown: PCWre=1, PCSrc=11/10/00.
//       jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
//   EXE_BR: PCWre=1; PCSrc=01 if zero else 00.
//   MEM: lw mRD=1; sw mWR=1, PCWre=1.
//   WB_AL: RegWre=1, PCWre=1, DBDataSrc=0; RegDst=10 (R-type) or 01 (addi/ori).
//   WB_LD: RegWre=1, PCWre=1, DBDataSrc=1, RegDst=01.
//   ALUSrcB=1 for addi/ori/lw/sw. ALUSrcA=1 for sll. ExtSel=0 only for ori.
//   beq ALUOp=001.
//  Latency (CLK cycles): ALU 4, lw 5, sw 4, beq 3, j/jr/jal 2.
//   halt stalls forever with PCWre=0.
//  Each instruction asserts PCWre in exactly one cycle, its last.
//   IRWre is asserted only in IF.
//  Reset: RST=1 at a posedge -> state=IF. While RST=1, every write enable
//   (PCWre, IRWre, RegWre, mWR) and mRD is forced 0, regardless of state.
//   Reset mid-instruction aborts it; no partial writes occur.
// CONFIGURATION
//  MULTICYCLE_CTRL_MEM_WAIT_EN
//   Defined: mem_ready port exists. IF and MEM hold while mem_ready=0.
//    IRWre is qualified with mem_ready. In MEM for sw, mWR stays asserted
//    and PCWre is asserted only when mem_ready=1.
//   Undefined: mem_ready port absent; IF and MEM each take one cycle.
// STRUCTURE
//  Package cpu_ctrl_pkg: opcode localparams, state codes, ALUOp, PCSrc and
//   RegDst encodings, shared with the ALU and datapath muxes.
//  Sub-module ctrl_decode: combinational opcode -> instruction class
//   (alu_r, alu_i, ls, br, jmp, halt, bad) plus ALUOp/ExtSel/ALUSrc.
//   The top holds the state register and the per-state output logic.
// TESTING
//  1. RST=1 for 2 cycles, opcode=add -> state_out=0000, all enables 0.
//     After RST falls: IRWre=1 in the first cycle.
//  2. add -> states 0,1,6,7,0. In WB_AL: RegWre=1, RegDst=10, PCWre=1.
//     PCWre is high in exactly 1 of the 4 cycles.
//  3. lw -> states 0,1,2,3,4. mRD=1 in MEM. In WB_LD: DBDataSrc=1, RegDst=01.
//     sw -> mWR=1 and PCWre=1 in MEM, then IF.
//  4. beq with zero=1 -> PCSrc=01 in EXE_BR. With zero=0 -> PCSrc=00.
//     Both return to IF after 3 cycles.
//  5. jal -> in ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11.
//     halt -> state 1000 held 20 cycles with PCWre=0. RST recovers to IF.
//  6. With MEM_WAIT_EN, mem_ready=0 for 3 cycles in IF -> state holds,
//     IRWre=0. RST asserted in WB_AL -> no RegWre that cycle, next state=IF.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, FSM states,
// ALUOp/PCSrc/RegDst selects, and the decoded instruction-class bundle.
package cpu_ctrl_pkg;

    localparam int OPW = 6;
    localparam int STW = 4;

    localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
    localparam logic [OPW-1:0] OP_OR   = 6'b010000;
    localparam logic [OPW-1:0] OP_AND  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
    localparam logic [OPW-1:0] OP_SLL  = 6'b011000;
    localparam logic [OPW-1:0] OP_SLT  = 6'b100110;
    localparam logic [OPW-1:0] OP_SW   = 6'b110000;
    localparam logic [OPW-1:0] OP_LW   = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
    localparam logic [OPW-1:0] OP_J    = 6'b111000;
    localparam logic [OPW-1:0] OP_JR   = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL  = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT = 6'b111111;

    typedef enum logic [STW-1:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] PC_P4  = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_RS  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    localparam logic [1:0] RD_31 = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic ls;
        logic br;
        logic jmp;
        logic halt;
        logic bad;
    } cls_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Opcode/flag inputs and datapath control outputs of the multicycle control unit.
// mem_ready exists only when MULTICYCLE_CTRL_MEM_WAIT_EN is defined.
interface multicycle_ctrl_if;
    import cpu_ctrl_pkg::*;

    logic [OPW-1:0] opcode;
    logic           zero;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    logic           mem_ready;
`endif
    logic           PCWre;
    logic           IRWre;
    logic           RegWre;
    logic           mRD;
    logic           mWR;
    logic           ALUSrcA;
    logic           ALUSrcB;
    logic           ExtSel;
    logic [2:0]     ALUOp;
    logic [1:0]     RegDst;
    logic           WrRegDSrc;
    logic           DBDataSrc;
    logic [1:0]     PCSrc;
    logic [STW-1:0] state_out;

    modport master (
        input  opcode, zero,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        input  mem_ready,
`endif
        output PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ExtSel,
               ALUOp, RegDst, WrRegDSrc, DBDataSrc, PCSrc, state_out
    );

    modport slave (
        output opcode, zero,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        output mem_ready,
`endif
        input  PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ExtSel,
               ALUOp, RegDst, WrRegDSrc, DBDataSrc, PCSrc, state_out
    );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode decode: instruction class plus ALU operation and operand selects.
// Zero latency; no flow control.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPW-1:0] opcode_i,
    output cls_t           cls_o,
    output logic [2:0]     alu_op_o,
    output logic           alu_src_a_o,
    output logic           alu_src_b_o,
    output logic           ext_sel_o
);

    always_comb begin
        cls_o       = '0;
        alu_op_o    = ALU_ADD;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 1'b0;
        ext_sel_o   = 1'b1;
        case (opcode_i)
            OP_ADD:  cls_o.alu_r = 1'b1;
            OP_SUB:  begin cls_o.alu_r = 1'b1; alu_op_o = ALU_SUB; end
            OP_OR:   begin cls_o.alu_r = 1'b1; alu_op_o = ALU_OR;  end
            OP_AND:  begin cls_o.alu_r = 1'b1; alu_op_o = ALU_AND; end
            OP_SLT:  begin cls_o.alu_r = 1'b1; alu_op_o = ALU_SLT; end
            OP_SLL:  begin cls_o.alu_r = 1'b1; alu_op_o = ALU_SLL; alu_src_a_o = 1'b1; end
            OP_ADDI: begin cls_o.alu_i = 1'b1; alu_src_b_o = 1'b1; end
            OP_ORI:  begin
                cls_o.alu_i = 1'b1;
                alu_op_o    = ALU_OR;
                alu_src_b_o = 1'b1;
                ext_sel_o   = 1'b0;
            end
            OP_SW, OP_LW:        begin cls_o.ls = 1'b1; alu_src_b_o = 1'b1; end
            OP_BEQ:              begin cls_o.br = 1'b1; alu_op_o = ALU_SUB; end
            OP_J, OP_JR, OP_JAL: cls_o.jmp  = 1'b1;
            OP_HALT:             cls_o.halt = 1'b1;
            default:             cls_o.bad  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (IF/ID/EXE/MEM/WB); ALU 4, lw 5, sw 4, beq 3, jumps 2 cycles.
// Memory stalls in IF/MEM only with MULTICYCLE_CTRL_MEM_WAIT_EN; otherwise never stalls.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    multicycle_ctrl_if.master   bus
);

    state_t state_q, state_d;
    cls_t   cls;
    logic   mem_rdy;
    logic   is_lw;
    logic   pc_wre, ir_wre, reg_wre, m_rd, m_wr, wr_src, db_src;
    logic [1:0] reg_dst, pc_src;

    ctrl_decode u_dec (
        .opcode_i    (bus.opcode),
        .cls_o       (cls),
        .alu_op_o    (bus.ALUOp),
        .alu_src_a_o (bus.ALUSrcA),
        .alu_src_b_o (bus.ALUSrcB),
        .ext_sel_o   (bus.ExtSel)
    );

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign mem_rdy = bus.mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    assign is_lw = (bus.opcode == OP_LW);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:     if (mem_rdy) state_d = S_ID;
            S_ID: begin
                if (cls.br)                    state_d = S_EXE_BR;
                else if (cls.ls)               state_d = S_EXE_LS;
                else if (cls.halt)             state_d = S_HALT;
                else if (cls.alu_r||cls.alu_i) state_d = S_EXE_AL;
                else                           state_d = S_IF;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    if (mem_rdy) state_d = is_lw ? S_WB_LD : S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        pc_wre  = 1'b0;
        ir_wre  = 1'b0;
        reg_wre = 1'b0;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        wr_src  = 1'b0;
        db_src  = 1'b0;
        reg_dst = RD_31;
        pc_src  = PC_P4;
        case (state_q)
            S_IF: ir_wre = mem_rdy;
            S_ID: begin
                // Jumps and unrecognised opcodes retire here; unknown ones fall through to PC+4.
                pc_wre = cls.jmp | cls.bad;
                case (bus.opcode)
                    OP_J:    pc_src = PC_JMP;
                    OP_JR:   pc_src = PC_RS;
                    OP_JAL:  begin pc_src = PC_JMP; reg_wre = 1'b1; end
                    default: ;
                endcase
            end
            S_EXE_BR: begin
                pc_wre = 1'b1;
                pc_src = bus.zero ? PC_BR : PC_P4;
            end
            S_MEM: begin
                if (is_lw) m_rd = 1'b1;
                else begin
                    m_wr   = 1'b1;
                    pc_wre = mem_rdy;
                end
            end
            S_WB_AL: begin
                reg_wre = 1'b1;
                pc_wre  = 1'b1;
                wr_src  = 1'b1;
                reg_dst = cls.alu_r ? RD_RD : RD_RT;
            end
            S_WB_LD: begin
                reg_wre = 1'b1;
                pc_wre  = 1'b1;
                wr_src  = 1'b1;
                db_src  = 1'b1;
                reg_dst = RD_RT;
            end
            default: ;
        endcase
        // Reset suppresses every architectural write in the same cycle it is seen.
        if (RST) begin
            pc_wre  = 1'b0;
            ir_wre  = 1'b0;
            reg_wre = 1'b0;
            m_rd    = 1'b0;
            m_wr    = 1'b0;
        end
    end

    assign bus.PCWre     = pc_wre;
    assign bus.IRWre     = ir_wre;
    assign bus.RegWre    = reg_wre;
    assign bus.mRD       = m_rd;
    assign bus.mWR       = m_wr;
    assign bus.RegDst    = reg_dst;
    assign bus.WrRegDSrc = wr_src;
    assign bus.DBDataSrc = db_src;
    assign bus.PCSrc     = pc_src;
    assign bus.state_out = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction vector table plus reset/halt/stall sequences.
// Stall sequence is built only with MULTICYCLE_CTRL_MEM_WAIT_EN.
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    multicycle_ctrl_if ifc ();

    multicycle_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       reg_wre;
        logic [1:0] reg_dst;
        logic [1:0] pc_src;
        logic       m_rd;
        logic       m_wr;
        logic       db_src;
        logic       wr_src;
        logic [2:0] alu_op;
        logic       src_a;
        logic       src_b;
        logic       ext;
    } ctl_t;

    typedef struct packed {
        logic [5:0]      op;
        logic            z;
        logic [2:0]      len;
        logic [2:0]      chk;
        logic [4:0][3:0] st;
        ctl_t            ctl;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    ctl_t act_ctl;
    int   n_tests = 0;
    int   n_fail  = 0;

    assign act_ctl = {ifc.RegWre, ifc.RegDst, ifc.PCSrc, ifc.mRD, ifc.mWR, ifc.DBDataSrc,
                      ifc.WrRegDSrc, ifc.ALUOp, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ExtSel};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mkv(logic [5:0] op, int z, int len, int chk,
                                 int s0, int s1, int s2, int s3, int s4,
                                 int rw, int rd, int ps, int mr, int mw, int db, int wr,
                                 int ao, int a, int b, int e);
        vec_t v;
        v.op  = op;
        v.z   = 1'(z);
        v.len = 3'(len);
        v.chk = 3'(chk);
        v.st  = {4'(s4), 4'(s3), 4'(s2), 4'(s1), 4'(s0)};
        v.ctl = {1'(rw), 2'(rd), 2'(ps), 1'(mr), 1'(mw), 1'(db), 1'(wr),
                 3'(ao), 1'(a), 1'(b), 1'(e)};
        return v;
    endfunction

    logic [4:0] enables;
    assign enables = {ifc.PCWre, ifc.IRWre, ifc.RegWre, ifc.mWR, ifc.mRD};

    initial begin
        logic [5:0] bad_op;
        bad_op = 6'b101010;
        RST = 1'b1;
        ifc.opcode = OP_ADD;
        ifc.zero   = 1'b0;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        ifc.mem_ready = 1'b1;
`endif
        //                op       z len chk  states          rw rd ps mr mw db wr ao a b e
        vecs[0]  = mkv(OP_ADD,  0, 4, 3, 0, 1, 6, 7, 0,  1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        vecs[1]  = mkv(OP_ADDI, 0, 4, 3, 0, 1, 6, 7, 0,  1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        vecs[2]  = mkv(OP_SLL,  0, 4, 2, 0, 1, 6, 7, 0,  0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1);
        vecs[3]  = mkv(OP_ORI,  0, 4, 2, 0, 1, 6, 7, 0,  0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
        vecs[4]  = mkv(OP_SLT,  0, 4, 3, 0, 1, 6, 7, 0,  1, 2, 0, 0, 0, 0, 1, 5, 0, 0, 1);
        vecs[5]  = mkv(OP_AND,  0, 4, 2, 0, 1, 6, 7, 0,  0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 1);
        vecs[6]  = mkv(OP_SUB,  0, 4, 3, 0, 1, 6, 7, 0,  1, 2, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        vecs[7]  = mkv(OP_LW,   0, 5, 3, 0, 1, 2, 3, 4,  0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        vecs[8]  = mkv(OP_LW,   0, 5, 4, 0, 1, 2, 3, 4,  1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1);
        vecs[9]  = mkv(OP_SW,   0, 4, 3, 0, 1, 2, 3, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
        vecs[10] = mkv(OP_BEQ,  1, 3, 2, 0, 1, 5, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        vecs[11] = mkv(OP_BEQ,  0, 3, 2, 0, 1, 5, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        vecs[12] = mkv(OP_J,    0, 2, 1, 0, 1, 0, 0, 0,  0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[13] = mkv(OP_JR,   0, 2, 1, 0, 1, 0, 0, 0,  0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[14] = mkv(OP_JAL,  0, 2, 1, 0, 1, 0, 0, 0,  1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[15] = mkv(bad_op,  0, 2, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[16] = mkv(OP_OR,   0, 4, 3, 0, 1, 6, 7, 0,  1, 2, 0, 0, 0, 0, 1, 3, 0, 0, 1);

        // Reset held for two cycles, then released.
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("rst_state_c%0d", c), 32'(ifc.state_out), 32'h0);
            check($sformatf("rst_enables_c%0d", c), 32'(enables), 32'h0);
        end
        RST = 1'b0;
        #1;
        check("post_rst_irwre", 32'(ifc.IRWre), 32'h1);

        for (int i = 0; i < NV; i++) begin
            ifc.opcode = vecs[i].op;
            ifc.zero   = vecs[i].z;
            #1;
            for (int k = 0; k < int'(vecs[i].len); k++) begin
                check($sformatf("v%0d_state_k%0d", i, k), 32'(ifc.state_out), 32'(vecs[i].st[k]));
                check($sformatf("v%0d_pcwre_k%0d", i, k), 32'(ifc.PCWre),
                      32'(k == int'(vecs[i].len) - 1));
                check($sformatf("v%0d_irwre_k%0d", i, k), 32'(ifc.IRWre), 32'(k == 0));
                if (k == int'(vecs[i].chk))
                    check($sformatf("v%0d_ctl_k%0d", i, k), 32'(act_ctl), 32'(vecs[i].ctl));
                tick();
            end
            check($sformatf("v%0d_back_to_if", i), 32'(ifc.state_out), 32'h0);
        end

        // Reset arriving in WB_AL must suppress that cycle's writes.
        ifc.opcode = OP_ADD;
        tick(); tick(); tick();
        check("abort_in_wb_al", 32'(ifc.state_out), 32'h7);
        RST = 1'b1;
        #1;
        check("abort_regwre", 32'(ifc.RegWre), 32'h0);
        check("abort_pcwre", 32'(ifc.PCWre), 32'h0);
        tick();
        RST = 1'b0;
        check("abort_state_if", 32'(ifc.state_out), 32'h0);

        // Halt parks the FSM until reset.
        ifc.opcode = OP_HALT;
        tick(); tick();
        for (int c = 0; c < 20; c++) begin
            check($sformatf("halt_state_c%0d", c), 32'(ifc.state_out), 32'h8);
            check($sformatf("halt_pcwre_c%0d", c), 32'(ifc.PCWre), 32'h0);
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check("halt_recover_state", 32'(ifc.state_out), 32'h0);
        check("halt_recover_irwre", 32'(ifc.IRWre), 32'h1);

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        ifc.opcode    = OP_SW;
        ifc.mem_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("ifwait_irwre_c%0d", c), 32'(ifc.IRWre), 32'h0);
            tick();
            check($sformatf("ifwait_state_c%0d", c), 32'(ifc.state_out), 32'h0);
        end
        ifc.mem_ready = 1'b1;
        #1;
        check("ifwait_release_irwre", 32'(ifc.IRWre), 32'h1);
        tick();
        check("ifwait_to_id", 32'(ifc.state_out), 32'h1);
        tick(); tick();
        ifc.mem_ready = 1'b0;
        #1;
        check("memwait_state", 32'(ifc.state_out), 32'h3);
        check("memwait_mwr", 32'(ifc.mWR), 32'h1);
        check("memwait_pcwre", 32'(ifc.PCWre), 32'h0);
        tick();
        check("memwait_hold", 32'(ifc.state_out), 32'h3);
        ifc.mem_ready = 1'b1;
        #1;
        check("memwait_done_pcwre", 32'(ifc.PCWre), 32'h1);
        tick();
        check("memwait_to_if", 32'(ifc.state_out), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
